// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
//   Shared types and constants for the seven-segment scan controller.
//   - NUM_DIGITS / SEL_W : display geometry (8 digits, 3-bit select)
//   - digit_t            : one hex nibble
//   - seg_t              : active-low segment vector {g,f,e,d,c,b,a}
//   - SEG_BLANK          : all segments off
//   - hex_to_seg_fn      : hex nibble -> active-low segment pattern
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic seg_t hex_to_seg_fn(input digit_t d);
    seg_t s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
//   Purely combinational hex nibble to seven-segment decoder.
//   Ports:
//     hex   in  4  nibble to display
//     seg_n out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seg
  import seg_scan_pkg::*;
(
  input  digit_t hex,
  output seg_t   seg_n
);

  assign seg_n = hex_to_seg_fn(hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit common-anode seven-segment
//   display. A prescaler divides clk into digit slots of TICK_DIV cycles; sel
//   walks 0..7 once per frame. Digit data is double-buffered: load writes the
//   shadow register and the shadow is copied to the active register only when
//   sel wraps 7->0, so a frame is never drawn from a mix of old and new data.
//
//   Build option: define SCAN_BLANK_EN to force all anodes off for the first
//   BLANK_CYCLES cycles of every slot (anti-ghosting). Without it BLANK_CYCLES
//   is ignored.
//
//   Parameters:
//     TICK_DIV      clk cycles per digit slot (>= 2)
//     BLANK_CYCLES  blank length at slot start (< TICK_DIV, SCAN_BLANK_EN only)
//   Ports:
//     clk        in   1   rising-edge clock
//     reset      in   1   synchronous active-high reset
//     load       in   1   capture strobe for digits_in/digit_en/dp_in
//     digits_in  in  32   digit i on [4i+3:4i]
//     digit_en   in   8   per-digit enable (0 keeps the anode off)
//     dp_in      in   8   per-digit decimal point, 1 = lit
//     pending    out  1   shadow holds data not yet shown
//     sel        out  3   digit currently scanned
//     anode_n    out  8   active-low anodes, at most one low
//     seg_n      out  7   active-low segments {g,f,e,d,c,b,a}
//     dp_n       out  1   active-low decimal point
//     frame_done out  1   one-cycle pulse on the first cycle of slot 0
//
//   Load handshake: load is a single-cycle strobe with no back-pressure; it is
//   always accepted. pending rises the cycle after load and falls on the frame
//   wrap that publishes the shadow. A load while pending overwrites the
//   shadow. A load on the wrap edge itself publishes the old shadow and keeps
//   the new data pending for the next frame.
// -----------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int TICK_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic [SEL_W-1:0]        sel,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output seg_t                    seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = '1;

  logic [PRE_W-1:0]          pre_q;
  logic [4*NUM_DIGITS-1:0]   act_digits_q, sh_digits_q;
  logic [NUM_DIGITS-1:0]     act_en_q, sh_en_q;
  logic [NUM_DIGITS-1:0]     act_dp_q, sh_dp_q;

  logic                      wrap;
  logic                      frame_wrap;
  logic                      transfer;
  logic [SEL_W-1:0]          sel_nx;
  logic [4*NUM_DIGITS-1:0]   digits_nx;
  logic [NUM_DIGITS-1:0]     en_nx;
  logic [NUM_DIGITS-1:0]     dp_vec_nx;
  digit_t                    nib_nx;
  seg_t                      seg_nx;
  logic [NUM_DIGITS-1:0]     anode_nx;
  logic                      dp_nx;

  // Everything below looks one slot ahead: the values computed here are what
  // the output registers take on the wrap edge, so the decode sees the active
  // data as it will be after a possible transfer on that same edge.
  always_comb begin
    wrap       = (pre_q == PRE_LAST);
    frame_wrap = wrap && (sel == SEL_LAST);
    transfer   = frame_wrap && pending;
    sel_nx     = sel + SEL_W'(1);
    digits_nx  = transfer ? sh_digits_q : act_digits_q;
    en_nx      = transfer ? sh_en_q     : act_en_q;
    dp_vec_nx  = transfer ? sh_dp_q     : act_dp_q;
    nib_nx     = digits_nx[{sel_nx, 2'b00} +: 4];
    anode_nx   = en_nx[sel_nx] ? ~(NUM_DIGITS'(1) << sel_nx) : ANODE_OFF;
    dp_nx      = en_nx[sel_nx] ? ~dp_vec_nx[sel_nx] : 1'b1;
  end

  hex_to_seg u_hex_to_seg (
    .hex   (nib_nx),
    .seg_n (seg_nx)
  );

  // Prescaler, digit select and frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (wrap) begin
        pre_q <= '0;
        sel   <= sel_nx;
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  // Shadow/active double buffer. The transfer reads the pre-edge shadow, so a
  // load on the same edge lands in the shadow and stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_digits_q <= '0;
      act_en_q     <= '0;
      act_dp_q     <= '0;
      sh_digits_q  <= '0;
      sh_en_q      <= '0;
      sh_dp_q      <= '0;
      pending      <= 1'b0;
    end else begin
      if (transfer) begin
        act_digits_q <= sh_digits_q;
        act_en_q     <= sh_en_q;
        act_dp_q     <= sh_dp_q;
      end
      if (load) begin
        sh_digits_q <= digits_in;
        sh_en_q     <= digit_en;
        sh_dp_q     <= dp_in;
        pending     <= 1'b1;
      end else if (transfer) begin
        pending     <= 1'b0;
      end
    end
  end

  // Segment and decimal-point outputs change only on slot boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else if (wrap) begin
      seg_n <= seg_nx;
      dp_n  <= dp_nx;
    end
  end

`ifdef SCAN_BLANK_EN
  localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);

  // The slot's anode pattern is parked in anode_tgt_q while the anodes are
  // held off, then released once the blank window has elapsed.
  logic [NUM_DIGITS-1:0] anode_tgt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_n     <= ANODE_OFF;
      anode_tgt_q <= ANODE_OFF;
    end else if (wrap) begin
      anode_tgt_q <= anode_nx;
      anode_n     <= (BLANK_CYCLES > 0) ? ANODE_OFF : anode_nx;
    end else if ((BLANK_CYCLES > 0) && (pre_q == BLANK_LAST)) begin
      anode_n     <= anode_tgt_q;
    end
  end
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = ^BLANK_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      anode_n <= ANODE_OFF;
    end else if (wrap) begin
      anode_n <= anode_nx;
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Self-checking bench for seg_scan_ctrl with TICK_DIV=4, BLANK_CYCLES=1.
//   A cycle-level reference model pushes the expected output word every clock
//   into exp_q; the scoreboard pops and compares it on the falling edge.
//   Directed checks cover the scenarios of interest on top of that.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int TD = 4;
  localparam int BC = 1;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        load = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = '0;
  logic        pending;
  logic [2:0]  sel;
  logic [7:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .pending    (pending),
    .sel        (sel),
    .anode_n    (anode_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F.
  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- reference model + expected queue ----------------
  // word layout: {pending, frame_done, sel[2:0], anode_n[7:0], seg_n[6:0], dp_n}
  logic [20:0] exp_q[$];

  int          m_pre;
  logic [2:0]  m_sel;
  logic [7:0]  m_anode, m_tgt;
  logic [6:0]  m_seg;
  logic        m_dp, m_fd, m_pend;
  logic [31:0] m_act_d, m_sh_d;
  logic [7:0]  m_act_en, m_sh_en, m_act_dp, m_sh_dp;

  always @(posedge clk) begin : model
    logic wrap;
    logic xfer;
    logic [7:0] an;
    cyc++;
    if (reset) begin
      m_pre = 0; m_sel = 0; m_anode = 8'hFF; m_tgt = 8'hFF; m_seg = 7'h7F;
      m_dp = 1'b1; m_fd = 1'b0; m_pend = 1'b0;
      m_act_d = '0; m_sh_d = '0; m_act_en = '0; m_sh_en = '0;
      m_act_dp = '0; m_sh_dp = '0;
    end else begin
      wrap = (m_pre == TD - 1);
      xfer = wrap && (m_sel == 3'd7) && m_pend;
      m_fd = wrap && (m_sel == 3'd7);
      if (xfer) begin
        m_act_d = m_sh_d; m_act_en = m_sh_en; m_act_dp = m_sh_dp;
        m_pend = 1'b0;
      end
      if (load) begin
        m_sh_d = digits_in; m_sh_en = digit_en; m_sh_dp = dp_in;
        m_pend = 1'b1;
      end
      if (wrap) begin
        m_sel = m_sel + 3'd1;
        an    = m_act_en[m_sel] ? ~(8'h01 << m_sel) : 8'hFF;
        m_seg = seg_tab[m_act_d[4*m_sel +: 4]];
        m_dp  = m_act_en[m_sel] ? ~m_act_dp[m_sel] : 1'b1;
`ifdef SCAN_BLANK_EN
        m_tgt   = an;
        m_anode = 8'hFF;
`else
        m_anode = an;
`endif
        m_pre = 0;
      end else begin
`ifdef SCAN_BLANK_EN
        if (m_pre == BC - 1) m_anode = m_tgt;
`endif
        m_pre++;
      end
    end
    exp_q.push_back({m_pend, m_fd, m_sel, m_anode, m_seg, m_dp});
  end

  // scoreboard
  always @(negedge clk) begin : scoreboard
    logic [20:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pending",    32'(pending),    32'(e[20]));
      check("sb_frame_done", 32'(frame_done), 32'(e[19]));
      check("sb_sel",        32'(sel),        32'(e[18:16]));
      check("sb_anode_n",    32'(anode_n),    32'(e[15:8]));
      check("sb_seg_n",      32'(seg_n),      32'(e[7:1]));
      check("sb_dp_n",       32'(dp_n),       32'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp);
    digits_in = d;
    digit_en  = en;
    dp_in     = dp;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_fd(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) check("fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic count_dark(input string tag, input int cycles);
    int low;
    low = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (anode_n != 8'hFF) low++;
    end
    check(tag, 32'(low), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int t0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_anode_n",    32'(anode_n),    32'hFF);
    check("rst_seg_n",      32'(seg_n),      32'h7F);
    check("rst_dp_n",       32'(dp_n),       32'd1);
    check("rst_sel",        32'(sel),        32'd0);
    check("rst_pending",    32'(pending),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    count_dark("dark_no_load", 40);

    // first load, all digits enabled, dp on digit 0
    do_load(32'h76543210, 8'hFF, 8'h01);
    check("pend_after_load", 32'(pending), 32'd1);
    wait_fd(40);
    check("s0_sel",  32'(sel),   32'd0);
    check("s0_seg",  32'(seg_n), 32'h40);
    check("s0_dp",   32'(dp_n),  32'd0);
`ifdef SCAN_BLANK_EN
    check("s0_blank", 32'(anode_n), 32'hFF);
`endif
    @(negedge clk);
    check("s0_anode", 32'(anode_n), 32'hFE);
    repeat (3) @(negedge clk);
    check("s1_sel",  32'(sel),   32'd1);
    check("s1_seg",  32'(seg_n), 32'h79);
    check("s1_dp",   32'(dp_n),  32'd1);
    @(negedge clk);
    check("s1_anode", 32'(anode_n), 32'hFD);

    // upper four digits disabled; frame length unchanged
    do_load(32'h76543210, 8'h0F, 8'h01);
    wait_fd(40);
    t0 = cyc;
    wait_fd(40);
    check("fd_period", 32'(cyc - t0), 32'd32);
    repeat (17) @(negedge clk);
    check("dis_sel",   32'(sel),     32'd4);
    check("dis_anode", 32'(anode_n), 32'hFF);

    // mid-frame load: old digits persist until the wrap
    wait_fd(40);
    repeat (9) @(negedge clk);
    do_load(32'hFFFFFFFF, 8'hFF, 8'h00);
    repeat (19) @(negedge clk);
    check("old_s7_sel", 32'(sel),   32'd7);
    check("old_s7_seg", 32'(seg_n), 32'h78);
    wait_fd(40);
    check("new_s0_seg",  32'(seg_n),   32'h0E);
    check("new_s0_pend", 32'(pending), 32'd0);

    // load coincident with the wrap edge
    do_load(32'h22222222, 8'hFF, 8'h00);
    repeat (30) @(negedge clk);
    do_load(32'h11111111, 8'hFF, 8'h00);
    check("coinc_fd",   32'(frame_done), 32'd1);
    check("coinc_pend", 32'(pending),    32'd1);
    check("coinc_seg",  32'(seg_n),      32'h24);
    wait_fd(40);
    check("late_seg",  32'(seg_n),   32'h79);
    check("late_pend", 32'(pending), 32'd0);

    // random loads at random times, checked by the scoreboard
    repeat (12) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      do_load($urandom, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    repeat (40) @(negedge clk);

    // reset during slot 5 with a load pending
    do_load(32'hFFFFFFFF, 8'hFF, 8'hFF);
    wait_fd(40);
    repeat (20) @(negedge clk);
    do_load(32'h88888888, 8'hFF, 8'hFF);
    check("pre_rst_sel", 32'(sel), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_anode_n",    32'(anode_n),    32'hFF);
    check("mid_rst_seg_n",      32'(seg_n),      32'h7F);
    check("mid_rst_dp_n",       32'(dp_n),       32'd1);
    check("mid_rst_sel",        32'(sel),        32'd0);
    check("mid_rst_pending",    32'(pending),    32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    count_dark("dark_after_rst", 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
